regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two sources.
  - The in-order pipeline WB stage (source A): fixed priority, never back-pressured at the port.
  - A long-latency unit (source L, e.g. divider or load-miss return): valid/ready handshake, buffered in a small FIFO.
- Keeps a 32-bit busy scoreboard of registers with outstanding L writes and drives issue-stage hazard detection.
- Raises a one-cycle pipeline hold to prevent L starvation.
- Sits between WB/long-latency units and the register file's WRaddr_i/WRdata_i/RegWrite_i inputs.

---
 rtl/regfile_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file's single write port between
// the in-order WB stage (source A, fixed priority) and a long-latency unit
// (source L, buffered in a small FIFO). Keeps a busy scoreboard of registers
// with outstanding L writes, drives issue hazard detection, and raises a
// one-cycle pipeline hold when the L head keeps losing to A.
//
// Optional build macro: WBARB_BYPASS_EN
//   defined   : an L request with FIFO empty and A idle is written in the same cycle
//   undefined : every L write goes through the FIFO (minimum one-cycle latency)
module regfile_write_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wba_valid_i,
    input  logic [4:0]  wba_addr_i,
    input  logic [31:0] wba_data_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_addr_i,
    input  logic [31:0] lu_data_i,
    input  logic        alloc_i,
    input  logic [4:0]  alloc_addr_i,
    input  logic [4:0]  chk_rs1_i,
    input  logic [4:0]  chk_rs2_i,
    input  logic [4:0]  chk_rd_i,
    output logic        hazard_o,
    output logic        hold_o,
    output logic [31:0] busy_o,
    output logic        RegWrite_o,
    output logic [4:0]  WRaddr_o,
    output logic [31:0] WRdata_o
);

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    // FIFO storage and control
    wr_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    wr_t               head;

    // Scoreboard and starvation state
    logic [NREGS-1:0]    busy_q, busy_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                hold_q, hold_d;

    // Per-cycle decisions
    logic fifo_empty;
    logic fifo_full;
    logic a_win;
    logic bypass;
    logic push;
    logic pop;
    logic l_commit;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign lu_ready_o = !fifo_full;
    assign head       = mem[rd_ptr_q];

    // A write to x0 is no request at all, so it never blocks L
    assign a_win = wba_valid_i && (wba_addr_i != ADDR_W'(0));

`ifdef WBARB_BYPASS_EN
    // Idle port and empty FIFO: L goes straight to the register file
    assign bypass = fifo_empty && !a_win && lu_valid_i && (lu_addr_i != ADDR_W'(0));
`else
    assign bypass = 1'b0;
`endif

    assign pop      = !a_win && !fifo_empty;
    assign push     = lu_valid_i && lu_ready_o && (lu_addr_i != ADDR_W'(0)) && !bypass;
    assign l_commit = pop || bypass;

    // Write-port mux: A first, then FIFO head (or bypassed L), else idle
    always_comb begin
        RegWrite_o = 1'b0;
        WRaddr_o   = '0;
        WRdata_o   = '0;
        if (a_win) begin
            RegWrite_o = 1'b1;
            WRaddr_o   = wba_addr_i;
            WRdata_o   = wba_data_i;
        end else if (pop) begin
            RegWrite_o = 1'b1;
            WRaddr_o   = head.addr;
            WRdata_o   = head.data;
        end else if (bypass) begin
            RegWrite_o = 1'b1;
            WRaddr_o   = lu_addr_i;
            WRdata_o   = lu_data_i;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap on power-of-2 depth
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO payload storage; contents are don't-care while not counted
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{addr: lu_addr_i, data: lu_data_i};
        end
    end

    // Scoreboard next-state: L commit clears, alloc sets (set wins), x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (l_commit) begin
            busy_d[WRaddr_o] = 1'b0;
        end
        if (alloc_i) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Starvation counter: counts cycles the waiting L head loses to A
    always_comb begin
        starve_d = starve_q;
        hold_d   = 1'b0;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (a_win) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                hold_d   = 1'b1;
                starve_d = '0;
            end else begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    // State registers; reset drops buffered writes and clears the scoreboard
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign busy_o = busy_q;
    assign hold_o = hold_q;

    // Issue hazard: any operand or destination with a pending L write
    assign hazard_o = busy_q[chk_rs1_i] | busy_q[chk_rs2_i] | busy_q[chk_rd_i];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected
// register-file writes (address, data, cycle) into a queue; a monitor matches
// every RegWrite_o it sees against that queue. Build with WBARB_BYPASS_EN to
// expect same-cycle L writes when the port is idle.
module tb_regfile_write_arbiter;

`ifdef WBARB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        wba_valid_i;
    logic [4:0]  wba_addr_i;
    logic [31:0] wba_data_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_addr_i;
    logic [31:0] lu_data_i;
    logic        alloc_i;
    logic [4:0]  alloc_addr_i;
    logic [4:0]  chk_rs1_i;
    logic [4:0]  chk_rs2_i;
    logic [4:0]  chk_rd_i;
    logic        hazard_o;
    logic        hold_o;
    logic [31:0] busy_o;
    logic        RegWrite_o;
    logic [4:0]  WRaddr_o;
    logic [31:0] WRdata_o;

    regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wba_valid_i(wba_valid_i), .wba_addr_i(wba_addr_i), .wba_data_i(wba_data_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
        .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
        .alloc_i(alloc_i), .alloc_addr_i(alloc_addr_i),
        .chk_rs1_i(chk_rs1_i), .chk_rs2_i(chk_rs2_i), .chk_rd_i(chk_rd_i),
        .hazard_o(hazard_o), .hold_o(hold_o), .busy_o(busy_o),
        .RegWrite_o(RegWrite_o), .WRaddr_o(WRaddr_o), .WRdata_o(WRdata_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
        wba_valid_i = v;
        wba_addr_i  = a;
        wba_data_i  = d;
    endtask

    task automatic set_l(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid_i = v;
        lu_addr_i  = a;
        lu_data_i  = d;
    endtask

    // Monitor: match each observed write to the expectation for this cycle
    task automatic monitor_step();
        int idx;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_write: got none required x%0d=%0h at cycle %0d",
                         q[i].addr, q[i].data, q[i].cyc);
                q.delete(i);
                i--;
            end
        end
        if (RegWrite_o) begin
            for (int i = 0; i < q.size(); i++) begin
                if (idx < 0 && q[i].cyc == cyc) idx = i;
            end
            if (idx < 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got x%0d=%0h required no write (cycle %0d)",
                         WRaddr_o, WRdata_o, cyc);
            end else begin
                chk("wr_addr", 32'(WRaddr_o), 32'(q[idx].addr));
                chk("wr_data", WRdata_o, q[idx].data);
                q.delete(idx);
            end
        end
    endtask

    task automatic stimulus();
        // Reset state
        rst_n_i = 1'b0;
        set_a(1'b0, 5'd0, 32'd0);
        set_l(1'b0, 5'd0, 32'd0);
        alloc_i = 1'b0; alloc_addr_i = 5'd0;
        chk_rs1_i = 5'd0; chk_rs2_i = 5'd0; chk_rd_i = 5'd0;
        tick();
        tick();
        chk("rst_ready", 32'(lu_ready_o), 32'd1);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
        chk("rst_hold", 32'(hold_o), 32'd0);
        rst_n_i = 1'b1;
        tick();

        // A priority over L in the same cycle
        alloc_i = 1'b1; alloc_addr_i = 5'd7;
        tick();
        alloc_i = 1'b0;
        chk("alloc7_busy", busy_o, 32'h0000_0080);
        set_a(1'b1, 5'd3, 32'h11);
        set_l(1'b1, 5'd7, 32'hAA);
        expect_wr(5'd3, 32'h11, cyc);
        expect_wr(5'd7, 32'hAA, cyc + 1);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_l(1'b0, 5'd0, 32'd0);
        chk("busy7_before_commit", busy_o, 32'h0000_0080);
        tick();
        chk("busy7_after_commit", busy_o, 32'd0);

        // Full FIFO: no push in the pop cycle while full
        set_a(1'b1, 5'd1, 32'h101);
        set_l(1'b1, 5'd8, 32'h88);
        chk("full_ready_c0", 32'(lu_ready_o), 32'd1);
        expect_wr(5'd1, 32'h101, cyc);
        expect_wr(5'd8, 32'h88, cyc + 4);
        tick();
        set_a(1'b1, 5'd1, 32'h102);
        set_l(1'b1, 5'd9, 32'h99);
        chk("full_ready_c1", 32'(lu_ready_o), 32'd1);
        expect_wr(5'd1, 32'h102, cyc);
        expect_wr(5'd9, 32'h99, cyc + 4);
        tick();
        set_a(1'b1, 5'd1, 32'h103);
        set_l(1'b1, 5'd10, 32'hA0);
        chk("full_ready_c2", 32'(lu_ready_o), 32'd0);
        expect_wr(5'd1, 32'h103, cyc);
        expect_wr(5'd10, 32'hA0, cyc + 4);
        tick();
        set_a(1'b1, 5'd1, 32'h104);
        chk("full_ready_c3", 32'(lu_ready_o), 32'd0);
        expect_wr(5'd1, 32'h104, cyc);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        chk("full_ready_pop_cycle", 32'(lu_ready_o), 32'd0);
        chk("full_no_hold", 32'(hold_o), 32'd0);
        tick();
        chk("full_ready_after_pop", 32'(lu_ready_o), 32'd1);
        tick();
        set_l(1'b0, 5'd0, 32'd0);
        tick();
        chk("full_drained_ready", 32'(lu_ready_o), 32'd1);

        // Scoreboard: hazard until commit, alloc on commit cycle keeps busy
        alloc_i = 1'b1; alloc_addr_i = 5'd10; chk_rs2_i = 5'd10;
        tick();
        alloc_i = 1'b0;
        chk("sb_hazard_set", 32'(hazard_o), 32'd1);
        chk("sb_busy10", busy_o, 32'h0000_0400);
        tick();
        chk("sb_hazard_hold", 32'(hazard_o), 32'd1);
        set_l(1'b1, 5'd10, 32'hCC);
        expect_wr(5'd10, 32'hCC, cyc + LAT);
        if (LAT == 1) begin
            tick();
            set_l(1'b0, 5'd0, 32'd0);
        end
        alloc_i = 1'b1; alloc_addr_i = 5'd10;
        chk("sb_hazard_commit_cycle", 32'(hazard_o), 32'd1);
        tick();
        alloc_i = 1'b0;
        set_l(1'b0, 5'd0, 32'd0);
        chk("sb_set_wins", busy_o, 32'h0000_0400);
        chk("sb_hazard_still", 32'(hazard_o), 32'd1);
        set_l(1'b1, 5'd10, 32'hDD);
        expect_wr(5'd10, 32'hDD, cyc + LAT);
        tick();
        set_l(1'b0, 5'd0, 32'd0);
        if (LAT == 1) tick();
        chk("sb_cleared", busy_o, 32'd0);
        chk("sb_hazard_clear", 32'(hazard_o), 32'd0);

        // rd check (WAW) and x0 alloc/check
        alloc_i = 1'b1; alloc_addr_i = 5'd11; chk_rs2_i = 5'd0; chk_rd_i = 5'd11;
        tick();
        chk("waw_hazard_rd", 32'(hazard_o), 32'd1);
        alloc_addr_i = 5'd0; chk_rd_i = 5'd0;
        tick();
        alloc_i = 1'b0;
        chk("x0_busy_unset", busy_o, 32'h0000_0800);
        chk("x0_hazard", 32'(hazard_o), 32'd0);

        // L latency to an idle port (same cycle with bypass)
        alloc_i = 1'b1; alloc_addr_i = 5'd12;
        tick();
        alloc_i = 1'b0;
        chk("byp_busy_pre", busy_o, 32'h0000_1800);
        set_l(1'b1, 5'd12, 32'h5);
        expect_wr(5'd12, 32'h5, cyc + LAT);
        tick();
        set_l(1'b0, 5'd0, 32'd0);
        if (LAT == 1) tick();
        chk("byp_busy_post", busy_o, 32'h0000_0800);
        set_l(1'b1, 5'd11, 32'h77);
        expect_wr(5'd11, 32'h77, cyc + LAT);
        tick();
        set_l(1'b0, 5'd0, 32'd0);
        if (LAT == 1) tick();
        chk("byp_busy_clear", busy_o, 32'd0);

        // Starvation: four lost cycles raise hold for exactly one cycle
        set_a(1'b1, 5'd2, 32'h200);
        set_l(1'b1, 5'd13, 32'h13);
        expect_wr(5'd2, 32'h200, cyc);
        expect_wr(5'd13, 32'h13, cyc + 5);
        chk("starve_hold_s0", 32'(hold_o), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            set_l(1'b0, 5'd0, 32'd0);
            set_a(1'b1, 5'd2, 32'h200 + 32'(i));
            expect_wr(5'd2, 32'h200 + 32'(i), cyc);
            chk("starve_hold_low", 32'(hold_o), 32'd0);
        end
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        chk("starve_hold_high", 32'(hold_o), 32'd1);
        tick();
        chk("starve_hold_one_cycle", 32'(hold_o), 32'd0);

        // Reset mid-stream with two buffered writes and a busy register
        alloc_i = 1'b1; alloc_addr_i = 5'd5;
        tick();
        alloc_i = 1'b0;
        set_a(1'b1, 5'd1, 32'h300);
        set_l(1'b1, 5'd14, 32'h14);
        expect_wr(5'd1, 32'h300, cyc);
        tick();
        set_a(1'b1, 5'd1, 32'h301);
        set_l(1'b1, 5'd15, 32'h15);
        expect_wr(5'd1, 32'h301, cyc);
        tick();
        set_l(1'b0, 5'd0, 32'd0);
        chk("mid_full_ready", 32'(lu_ready_o), 32'd0);
        chk("mid_busy5", busy_o, 32'h0000_0020);
        set_a(1'b0, 5'd0, 32'd0);
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(lu_ready_o), 32'd1);
        chk("mid_rst_busy", busy_o, 32'd0);
        chk("mid_rst_regwrite", 32'(RegWrite_o), 32'd0);
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_ready", 32'(lu_ready_o), 32'd1);
        chk("post_rst_busy", busy_o, 32'd0);
        tick();
    endtask

    initial begin
        fork
            stimulus();
            forever begin
                @(negedge clk_i);
                monitor_step();
            end
        join_any
        disable fork;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
